// File: rtl/conv_scheduler.sv
// Convolution sequencer: streams every filter coefficient index once, then sweeps the filter
// centre over all valid positions and issues the pixel coordinates of each window.
module conv_scheduler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  img_w_i,
  input  logic [7:0]  img_h_i,
  input  logic [7:0]  img_d_i,
  input  logic [2:0]  filter_dim_i,
  input  logic        filter_blocked_i,
  input  logic        issue_blocked_i,
  output logic        filter_valid_o,
  output logic [12:0] filter_issue_counter_o,
  output logic        issue_valid_o,
  output logic [7:0]  issue_x_o,
  output logic [7:0]  issue_y_o,
  output logic [7:0]  issue_z_o,
  output logic [7:0]  center_x_o,
  output logic [7:0]  center_y_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [1:0] {StIdle, StFilter, StScan, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  dim_q, dim_d;
  logic [7:0]  w_q, w_d, h_q, h_d, d_q, d_d;
  logic [12:0] n_q, n_d, cnt_q, cnt_d;
  logic [7:0]  cx_q, cx_d, cy_q, cy_d, z_q, z_d;
  logic [2:0]  i_q, i_d, j_q, j_d;
  logic        err_q, err_d;

  logic        cfg_ok;
  logic [5:0]  dim_sq;
  logic [13:0] n_full;
  logic [7:0]  r8, cx_last, cy_last;
  logic        i_last, j_last, z_last;

  assign cfg_ok = filter_dim_i[0] && (img_d_i != 8'd0) && (img_d_i <= 8'd128) &&
                  (img_w_i >= {5'd0, filter_dim_i}) && (img_h_i >= {5'd0, filter_dim_i});
  assign dim_sq = {3'd0, filter_dim_i} * {3'd0, filter_dim_i};
  assign n_full = {8'd0, dim_sq} * {6'd0, img_d_i};

  assign r8      = {6'd0, dim_q[2:1]};
  assign cx_last = w_q - r8 - 8'd1;
  assign cy_last = h_q - r8 - 8'd1;
  assign i_last  = (i_q == dim_q - 3'd1);
  assign j_last  = (j_q == dim_q - 3'd1);
  assign z_last  = (z_q == d_q - 8'd1);

  always_comb begin
    state_d = state_q;
    dim_d   = dim_q;
    w_d     = w_q;
    h_d     = h_q;
    d_d     = d_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    z_d     = z_q;
    i_d     = i_q;
    j_d     = j_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          err_d = !cfg_ok;
          if (cfg_ok) begin
            dim_d   = filter_dim_i;
            w_d     = img_w_i;
            h_d     = img_h_i;
            d_d     = img_d_i;
            n_d     = n_full[12:0];
            cnt_d   = 13'd0;
            cx_d    = 8'd0;
            cy_d    = 8'd0;
            state_d = StFilter;
          end else begin
            state_d = StDone;
          end
        end
      end
      StFilter: begin
        if (!filter_blocked_i) begin
          if (cnt_q == n_q - 13'd1) begin
            cnt_d   = 13'd0;
            cx_d    = r8;
            cy_d    = r8;
            i_d     = 3'd0;
            j_d     = 3'd0;
            z_d     = 8'd0;
            state_d = StScan;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
      end
      StScan: begin
        if (!issue_blocked_i) begin
          i_d = i_q + 3'd1;
          if (i_last) begin
            i_d = 3'd0;
            j_d = j_q + 3'd1;
            if (j_last) begin
              j_d = 3'd0;
              z_d = z_q + 8'd1;
              if (z_last) begin
                // Window complete: step to the next centre with no bubble cycle.
                z_d = 8'd0;
                if (cx_q == cx_last) begin
                  cx_d = r8;
                  if (cy_q == cy_last) state_d = StDone;
                  else                 cy_d    = cy_q + 8'd1;
                end else begin
                  cx_d = cx_q + 8'd1;
                end
              end
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dim_q   <= 3'd0;
      w_q     <= 8'd0;
      h_q     <= 8'd0;
      d_q     <= 8'd0;
      n_q     <= 13'd0;
      cnt_q   <= 13'd0;
      cx_q    <= 8'd0;
      cy_q    <= 8'd0;
      z_q     <= 8'd0;
      i_q     <= 3'd0;
      j_q     <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
      w_q     <= w_d;
      h_q     <= h_d;
      d_q     <= d_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
      i_q     <= i_d;
      j_q     <= j_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    filter_valid_o         = (state_q == StFilter);
    filter_issue_counter_o = cnt_q;
    issue_valid_o          = (state_q == StScan);
    issue_x_o              = 8'd0;
    issue_y_o              = 8'd0;
    issue_z_o              = 8'd0;
    // Coordinates are forced to zero outside SCAN so no stale window value leaks out.
    if (issue_valid_o) begin
      issue_x_o = cx_q - r8 + {5'd0, i_q};
      issue_y_o = cy_q - r8 + {5'd0, j_q};
      issue_z_o = z_q;
    end
    center_x_o = cx_q;
    center_y_o = cy_q;
    busy_o     = (state_q == StFilter) || (state_q == StScan);
    done_o     = (state_q == StDone);
    error_o    = err_q;
  end

endmodule

// File: tb/tb_conv_scheduler.sv
// Directed bench for conv_scheduler: sequences are compared against a nested-loop window model.
module tb_conv_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  img_w_i, img_h_i, img_d_i;
  logic [2:0]  filter_dim_i;
  logic        filter_blocked_i, issue_blocked_i;
  logic        filter_valid_o;
  logic [12:0] filter_issue_counter_o;
  logic        issue_valid_o;
  logic [7:0]  issue_x_o, issue_y_o, issue_z_o, center_x_o, center_y_o;
  logic        busy_o, done_o, error_o;

  conv_scheduler dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .start_i                (start_i),
    .img_w_i                (img_w_i),
    .img_h_i                (img_h_i),
    .img_d_i                (img_d_i),
    .filter_dim_i           (filter_dim_i),
    .filter_blocked_i       (filter_blocked_i),
    .issue_blocked_i        (issue_blocked_i),
    .filter_valid_o         (filter_valid_o),
    .filter_issue_counter_o (filter_issue_counter_o),
    .issue_valid_o          (issue_valid_o),
    .issue_x_o              (issue_x_o),
    .issue_y_o              (issue_y_o),
    .issue_z_o              (issue_z_o),
    .center_x_o             (center_x_o),
    .center_y_o             (center_y_o),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .error_o                (error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [12:0] fq[$];
  logic [39:0] iq[$];
  logic [39:0] eq[$];
  int first_busy, first_fv, first_iv, first_cnt, first_err, done_busy;
  int both_viol, hold_viol;
  int dc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int dim, input int w, input int h, input int d);
    filter_dim_i = 3'(dim);
    img_w_i      = 8'(w);
    img_h_i      = 8'(h);
    img_d_i      = 8'(d);
  endtask

  function automatic logic [57:0] all_outs();
    return {filter_valid_o, filter_issue_counter_o, issue_valid_o, issue_x_o, issue_y_o,
            issue_z_o, center_x_o, center_y_o, busy_o, done_o, error_o};
  endfunction

  // mode 0: no stalls, 1: issue_blocked on odd cycles, 2: filter_blocked on odd cycles,
  // 3: extra start pulse plus config change mid-SCAN.
  task automatic run(input int mode, input int max_cyc, output int done_cyc);
    logic [57:0] snap, prev_snap;
    int          prev_blk;
    fq.delete();
    iq.delete();
    both_viol = 0;
    hold_viol = 0;
    prev_blk  = 0;
    prev_snap = '0;
    done_cyc  = -1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c > 1) begin
        @(posedge clk_i);
        #1;
      end
      if (c == 1) begin
        first_busy = int'(busy_o);
        first_fv   = int'(filter_valid_o);
        first_iv   = int'(issue_valid_o);
        first_cnt  = int'(filter_issue_counter_o);
        first_err  = int'(error_o);
      end
      snap = all_outs();
      if (prev_blk != 0 && snap !== prev_snap) hold_viol++;
      if (done_o) begin
        done_cyc  = c;
        done_busy = int'(busy_o);
        break;
      end
      if (filter_valid_o && issue_valid_o) both_viol++;
      filter_blocked_i = (mode == 2) && (c % 2 == 1);
      issue_blocked_i  = (mode == 1) && (c % 2 == 1);
      if (mode == 3) begin
        start_i = (c == 15);
        if (c == 15) cfg(5, 9, 9, 3);
      end
      if (filter_valid_o && !filter_blocked_i) fq.push_back(filter_issue_counter_o);
      if (issue_valid_o && !issue_blocked_i)
        iq.push_back({issue_x_o, issue_y_o, issue_z_o, center_x_o, center_y_o});
      prev_blk  = int'((filter_valid_o && filter_blocked_i) || (issue_valid_o && issue_blocked_i));
      prev_snap = snap;
    end
    filter_blocked_i = 1'b0;
    issue_blocked_i  = 1'b0;
    start_i          = 1'b0;
  endtask

  // Reference: centres y-outer/x-inner, window z-outer, then y, then x.
  task automatic cmp_seq(input string tag, input int dim, input int w, input int h, input int d);
    int r, n, bad;
    r = dim / 2;
    n = dim * dim * d;
    eq.delete();
    for (int cy = r; cy <= h - 1 - r; cy++)
      for (int cx = r; cx <= w - 1 - r; cx++)
        for (int z = 0; z < d; z++)
          for (int j = 0; j < dim; j++)
            for (int i = 0; i < dim; i++)
              eq.push_back({8'(cx - r + i), 8'(cy - r + j), 8'(z), 8'(cx), 8'(cy)});
    chk({tag, "_fcount"}, fq.size(), n);
    bad = 0;
    foreach (fq[k]) if (int'(fq[k]) != k) bad++;
    chk({tag, "_fseq"}, bad, 0);
    chk({tag, "_icount"}, iq.size(), eq.size());
    bad = 0;
    foreach (eq[k]) if (k >= iq.size() || iq[k] !== eq[k]) bad++;
    chk({tag, "_iseq"}, bad, 0);
    chk({tag, "_both_valid"}, both_viol, 0);
    chk({tag, "_hold"}, hold_viol, 0);
  endtask

  initial begin
    int bad;
    rst_i            = 1'b1;
    start_i          = 1'b0;
    filter_blocked_i = 1'b0;
    issue_blocked_i  = 1'b0;
    cfg(3, 4, 4, 1);
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_outputs", all_outs(), 0);
    rst_i = 1'b0;

    // dim 3, 4x4x1, no stalls
    run(0, 200, dc);
    chk("t1_first_busy", first_busy, 1);
    chk("t1_first_fvalid", first_fv, 1);
    chk("t1_first_cnt", first_cnt, 0);
    chk("t1_done_cycle", dc, 46);
    chk("t1_done_busy", done_busy, 0);
    chk("t1_first_issue", iq[0], {8'd0, 8'd0, 8'd0, 8'd1, 8'd1});
    chk("t1_last_issue", iq[35], {8'd3, 8'd3, 8'd0, 8'd2, 8'd2});
    cmp_seq("t1", 3, 4, 4, 1);

    // issue_blocked on odd cycles: 35 stall cycles inside SCAN
    run(1, 300, dc);
    chk("t2_done_cycle", dc, 81);
    cmp_seq("t2", 3, 4, 4, 1);

    // dim 1, 2x2x2, filter_blocked on odd cycles: 2 stall cycles in FILTER
    cfg(1, 2, 2, 2);
    run(2, 100, dc);
    chk("t3_done_cycle", dc, 13);
    chk("t3_issue2", iq[2], {8'd1, 8'd0, 8'd0, 8'd1, 8'd0});
    chk("t3_issue4", iq[4], {8'd0, 8'd1, 8'd0, 8'd0, 8'd1});
    cmp_seq("t3", 1, 2, 2, 2);

    // illegal configs: even dim, then image narrower than the filter
    cfg(4, 4, 4, 1);
    run(0, 10, dc);
    chk("t4_done_cycle", dc, 1);
    chk("t4_error", first_err, 1);
    chk("t4_busy", first_busy, 0);
    chk("t4_valid", first_fv + first_iv, 0);
    bad = 0;
    repeat (4) begin
      @(posedge clk_i);
      #1;
      if (filter_valid_o || issue_valid_o || busy_o) bad++;
    end
    chk("t4_quiet_after", bad, 0);
    chk("t4_error_held", error_o, 1);
    cfg(3, 2, 4, 1);
    run(0, 10, dc);
    chk("t5_done_cycle", dc, 1);
    chk("t5_error", first_err, 1);
    chk("t5_valid", first_fv + first_iv, 0);

    // legal start clears error; second start mid-SCAN with changed config is ignored
    cfg(3, 4, 4, 1);
    run(3, 200, dc);
    chk("t6_error_cleared", first_err, 0);
    chk("t6_done_cycle", dc, 46);
    cmp_seq("t6", 3, 4, 4, 1);

    // asynchronous reset in the middle of FILTER, then a fresh run
    cfg(3, 4, 4, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("t7_cnt_before_rst", filter_issue_counter_o, 3);
    rst_i = 1'b1;
    #1;
    chk("t7_outputs_in_rst", all_outs(), 0);
    #1;
    rst_i = 1'b0;
    run(0, 200, dc);
    chk("t7_restart_cnt", first_cnt, 0);
    chk("t7_done_cycle", dc, 46);
    cmp_seq("t7", 3, 4, 4, 1);

    // largest filter: N = 6272, single centre (3,3)
    cfg(7, 7, 7, 128);
    run(0, 13000, dc);
    chk("t8_done_cycle", dc, 12545);
    chk("t8_last_index", fq[6271], 6271);
    cmp_seq("t8", 7, 7, 7, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_scheduler.md
# conv_scheduler

Sequencer that drives the convolution allocator. On a start pulse it streams every filter coefficient index once, then sweeps the filter centre across every valid position of a W×H×D input volume. For each centre it issues the pixel coordinates of the full filter window. It sits between the host configuration registers and the allocator, and owns all centre, coordinate and filter-index generation.

## Interface
Parameters:
- none. Widths are fixed: 8-bit coordinates, 13-bit filter index, 3-bit filter_dim.

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request, sampled only in IDLE
- img_w, img_h  in  8 each  image width/height minus 0 (1..255)
- img_d  in  8  channel depth (1..128)
- filter_dim  in  3  filter side length, legal values 1, 3, 5, 7
- filter_blocked  in  1  allocator cannot accept a filter index this cycle
- issue_blocked  in  1  allocator cannot accept a pixel coordinate this cycle
- filter_valid  out  1  filter_issue_counter is valid
- filter_issue_counter  out  13  coefficient index 0..N-1, N = dim·dim·img_d
- issue_valid  out  1  issue_x/y/z are valid
- issue_x, issue_y, issue_z  out  8 each  pixel coordinate
- center_x, center_y  out  8 each  current filter centre
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- error  out  1  config rejected; held until the next accepted start

## Operation
- Config inputs are latched on the start cycle and ignored afterwards. start while busy is ignored.
- r = filter_dim>>1. Centres run over x = r..img_w-1-r and y = r..img_h-1-r, x fastest.
- Config check at start: error if filter_dim is even or 0, img_d is 0 or >128, or img_w < dim or img_h < dim.
- State FSM:
  - IDLE: start with a legal config goes to FILTER. start with an illegal config goes to DONE with error=1 and no valid outputs.
  - FILTER: filter_valid=1. The counter advances on each accepted transfer. After index N-1 is accepted, go to SCAN.
  - SCAN: issue_valid=1. Window order is z outer, then y, then x inner, with x = cx-r+i and y = cy-r+j. After the last window element, advance to the next centre in the same cycle (no bubble). After the last element of the last centre, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Transfer rule: a value moves when valid=1 and blocked=0 at the posedge. While blocked, every output holds.
- No out-of-bounds coordinate is ever issued.
- Index arithmetic is unsigned. The maximum N is 49·128=6272, which fits in 13 bits.

## Timing
- Reset: all outputs 0, FSM IDLE, error 0.
- If start is sampled at edge k, then at edge k+1 busy=1 and filter_valid=1 with counter 0. error is cleared at the same edge.
- FILTER lasts N cycles plus filter_blocked stall cycles. The first issue_valid appears the cycle after the last accepted filter index.
- center_x/center_y update on the same edge that the first coordinate of the new window is presented.
- Unstalled run length: start → done = 1 + N + Cx·Cy·N cycles, where Cx = img_w-2r and Cy = img_h-2r.
- Both valids are never high in the same cycle.
- rst asserted mid-run clears everything immediately. No done pulse is produced.

## Test plan
- dim=3, 4×4×1, no stalls: counter 0..8 over 9 cycles. Then 36 issues: the first is (0,0,0) with centre (1,1), and the last is (3,3,0) with centre (2,2). done is seen 46 cycles after start.
- Same config with issue_blocked toggled every other cycle: the coordinate sequence is identical and outputs hold while blocked. done is delayed by the number of stalled cycles.
- dim=1, 2×2×2: N=2. Issues are (0,0,0),(0,0,1),(1,0,0),(1,0,1),(0,1,0)… in that order, 8 total.
- dim=4 or img_w=2 with dim=3: error=1, done the cycle after start, and no valid ever asserted.
- start pulsed again mid-SCAN is ignored. rst pulsed mid-FILTER returns all outputs to 0 asynchronously, and a fresh start then restarts the counter at 0.
- dim=7, 7×7×128: N=6272, the counter reaches 6271 without wrap, and exactly one centre (3,3) is scanned.
